prod_accumulator: RTL and testbench
===================================

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, giving the accumulator and result width in bits (legal range 8..16).
REQ-002 SHALL have parameter N_TERMS, default 4, giving the number of products summed per frame (legal range 2..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream product valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a product this cycle.
REQ-008 SHALL have port in_prod, input, 8 bits: unsigned product from the 4x4 multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_sum, output, ACC_W bits: frame sum, saturated.
REQ-012 SHALL have port out_ovf, output, 1 bit: saturation occurred in this frame.

Function
REQ-013 SHALL implement a two-state FSM: ACC (collecting) and HOLD (result presented).
REQ-014 SHALL drive in_ready=1 in ACC and in_ready=0 in HOLD, combinationally from state only.
REQ-015 SHALL accept a beat when in_valid && in_ready; no beat is accepted otherwise, and state is unchanged.
REQ-016 SHALL, on each accepted beat in ACC, set acc <= sat(acc + zero-extended in_prod) and increment the term counter.
REQ-017 SHALL saturate: if acc + in_prod exceeds 2^ACC_W-1, store 2^ACC_W-1 and set a sticky ovf flag for the frame.
REQ-018 SHALL, on the N_TERMS-th accepted beat, register the final saturated sum into out_sum and ovf into out_ovf, and enter HOLD on the next edge.
REQ-019 SHALL assert out_valid in HOLD, one cycle after the final beat is accepted (latency 1).
REQ-020 SHALL hold out_sum, out_ovf and out_valid stable in HOLD until out_valid && out_ready.
REQ-021 SHALL, on the out handshake, zero acc, counter and ovf, and return to ACC on the next edge; in_ready rises the following cycle.
REQ-022 SHALL hold out_sum and out_ovf at their last values while in ACC; out_valid=0 in ACC.
REQ-023 SHALL, when clear=1, zero acc, counter and ovf, drop out_valid, and enter ACC on the next edge, discarding any beat or result presented that cycle.
REQ-024 SHALL give rst priority over clear, and clear priority over both handshakes.
REQ-025 SHALL ignore out_ready while in ACC and ignore in_valid and in_prod while in HOLD.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter ACC and set acc=0, counter=0, ovf=0, out_sum=0, out_ovf=0, out_valid=0.
REQ-027 SHALL have in_ready=1 in the first cycle after reset deasserts.
REQ-028 SHALL, on rst asserted mid-frame or in HOLD, lose all partial and held results with no output handshake.

Verification
REQ-029 Default params; drive products 15,30,45,60 on consecutive cycles -> out_valid=1 the next cycle, out_sum=150, out_ovf=0.
REQ-030 Four products of 225 with out_ready=0 for 5 cycles -> out_sum=900 held stable, in_ready=0 throughout; out_ready=1 -> ACC the next cycle, in_ready=1.
REQ-031 ACC_W=8; products 200,100,10,1 -> out_sum=255, out_ovf=1; the next frame of 1,1,1,1 -> out_sum=4, out_ovf=0.
REQ-032 Two products accepted, then clear=1 with in_valid=1 and in_prod=50 -> beat discarded; the next frame of 1,2,3,4 -> out_sum=10.
REQ-033 in_valid toggling every other cycle with products 5,6,7,8 -> out_sum=26; no beat is counted while in_valid=0.
REQ-034 rst=1 and clear=1 asserted together while in HOLD -> all outputs 0, then in_ready=1 after rst drops.

Source files
------------

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums N_TERMS unsigned 8-bit products per frame into a
// saturating ACC_W-bit accumulator and presents the result with a
// valid/ready handshake.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset (highest priority)
//   clear      - synchronous frame abort (beats over both handshakes)
//   in_valid   - upstream product valid
//   in_ready   - block accepts a product this cycle (decoded from state)
//   in_prod    - unsigned 8-bit product
//   out_valid  - frame result valid
//   out_ready  - downstream accepts the result
//   out_sum    - saturated frame sum
//   out_ovf    - saturation occurred in the frame
module prod_accumulator #(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [SUM_W-1:0] sum_wide;
  logic             sum_over;
  logic [ACC_W-1:0] sum_sat;
  logic             accept;

  // One extra bit catches the carry out of the accumulator; clamp on carry.
  always_comb begin
    sum_wide = {1'b0, acc} + SUM_W'(in_prod);
    sum_over = sum_wide[ACC_W];
    sum_sat  = sum_over ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  assign in_ready = (state == ST_ACC);
  assign accept   = in_valid && in_ready;

  // Frame FSM with datapath; rst > clear > handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc <= sum_sat;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | sum_over;
            // Final term: publish the result and present it next cycle.
            if (cnt == LAST_TERM) begin
              out_sum   <= sum_sat;
              out_ovf   <= ovf | sum_over;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: two instances (ACC_W=12 and ACC_W=8) share
// one stimulus stream; a frame-level model predicts every output each cycle
// and directed literal checks pin the model.
module tb_prod_accumulator;

  localparam int unsigned N_TERMS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_prod = 8'd0;
  logic out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [11:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prod_accumulator #(.ACC_W(12), .N_TERMS(N_TERMS)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  prod_accumulator #(.ACC_W(8), .N_TERMS(N_TERMS)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame model: collect accepted products, compute the total at frame end.
  // Products are non-negative, so per-beat saturation equals min(total, max)
  // and the sticky flag equals (total > max).
  int m_frame[$];
  bit m_hold  = 1'b0;
  bit m_valid = 1'b0;
  int m_sum_a = 0, m_sum_b = 0;
  bit m_ovf_a = 1'b0, m_ovf_b = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_frame.delete();
      m_hold = 1'b0; m_valid = 1'b0;
      m_sum_a = 0; m_sum_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else if (clear) begin
      m_frame.delete();
      m_hold = 1'b0; m_valid = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_frame.push_back(int'(in_prod));
        if (m_frame.size() == N_TERMS) begin
          int total;
          total = 0;
          foreach (m_frame[i]) total += m_frame[i];
          m_sum_a = (total > 4095) ? 4095 : total;
          m_ovf_a = (total > 4095);
          m_sum_b = (total > 255) ? 255 : total;
          m_ovf_b = (total > 255);
          m_valid = 1'b1;
          m_hold  = 1'b1;
          m_frame.delete();
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0; m_valid = 1'b0;
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    chk("a_in_ready",  int'(a_in_ready),  int'(!m_hold));
    chk("a_out_valid", int'(a_out_valid), int'(m_valid));
    chk("a_out_sum",   int'(a_out_sum),   m_sum_a);
    chk("a_out_ovf",   int'(a_out_ovf),   int'(m_ovf_a));
    chk("b_in_ready",  int'(b_in_ready),  int'(!m_hold));
    chk("b_out_valid", int'(b_out_valid), int'(m_valid));
    chk("b_out_sum",   int'(b_out_sum),   m_sum_b);
    chk("b_out_ovf",   int'(b_out_ovf),   int'(m_ovf_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit v, input int p);
    in_valid = v;
    in_prod  = 8'(p);
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("lit_reset_sum",   int'(a_out_sum),   0);
    chk("lit_reset_valid", int'(a_out_valid), 0);
    step();
    chk("lit_ready_after_reset", int'(a_in_ready), 1);

    // Basic frame.
    beat(1, 15); beat(1, 30); beat(1, 45); beat(1, 60);
    chk("lit_f1_valid", int'(a_out_valid), 1);
    chk("lit_f1_sum",   int'(a_out_sum),   150);
    chk("lit_f1_ovf",   int'(a_out_ovf),   0);
    handshake();

    // Backpressure: result held, inputs ignored while holding.
    beat(1, 225); beat(1, 225); beat(1, 225); beat(1, 225);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 8'd99;
      chk("lit_f2_hold_sum",   int'(a_out_sum),  900);
      chk("lit_f2_hold_ready", int'(a_in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    chk("lit_f2_b_sum", int'(b_out_sum), 255);
    handshake();
    chk("lit_f2_ready_back", int'(a_in_ready),  1);
    chk("lit_f2_valid_low",  int'(a_out_valid), 0);

    // Saturation at 8 bits, then a clean frame clears the sticky flag.
    out_ready = 1'b1;   // ignored while collecting
    beat(1, 200); beat(1, 100); beat(1, 10);
    out_ready = 1'b0;
    beat(1, 1);
    chk("lit_f3_b_sum", int'(b_out_sum), 255);
    chk("lit_f3_b_ovf", int'(b_out_ovf), 1);
    chk("lit_f3_a_sum", int'(a_out_sum), 311);
    chk("lit_f3_a_ovf", int'(a_out_ovf), 0);
    handshake();
    beat(1, 1); beat(1, 1); beat(1, 1); beat(1, 1);
    chk("lit_f4_b_sum", int'(b_out_sum), 4);
    chk("lit_f4_b_ovf", int'(b_out_ovf), 0);
    handshake();

    // Abort mid-frame; the beat presented with clear is discarded.
    beat(1, 1); beat(1, 2);
    clear = 1'b1;
    beat(1, 50);
    clear = 1'b0;
    chk("lit_clear_sum_kept", int'(a_out_sum), 4);
    beat(1, 1); beat(1, 2); beat(1, 3); beat(1, 4);
    chk("lit_f5_sum", int'(a_out_sum), 10);
    handshake();

    // Gapped input.
    beat(1, 5); beat(0, 99); beat(1, 6); beat(0, 99);
    beat(1, 7); beat(0, 99); beat(1, 8);
    chk("lit_f6_sum",   int'(a_out_sum),   26);
    chk("lit_f6_valid", int'(a_out_valid), 1);

    // rst with clear while holding.
    rst = 1'b1; clear = 1'b1;
    step();
    chk("lit_rst_valid", int'(a_out_valid), 0);
    chk("lit_rst_sum",   int'(a_out_sum),   0);
    chk("lit_rst_ovf",   int'(b_out_ovf),   0);
    rst = 1'b0; clear = 1'b0;
    step();
    chk("lit_rst_ready", int'(a_in_ready), 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
